// File: rtl/div_pkg.sv
// Shared types for the DIV/IDIV sequencer: FSM states, error codes, operand record.
package div_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_FIX, S_DONE} state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ZERO    = 2'b01,
    ERR_OVF     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Operands after byte/word extension, held stable for the whole operation.
  typedef struct packed {
    logic        size;
    logic        sgn;
    logic [31:0] dvd;
    logic [15:0] dvs;
  } op_s;
endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling: operand magnitudes for launch, quotient range
// check and result re-signing for the fix-up step.
module div_sign_fix
  import div_pkg::*;
(
  input  logic        size_i,
  input  logic        is_signed_i,
  input  logic [31:0] dvd_i,
  input  logic [15:0] dvs_i,
  input  logic [31:0] qm_i,
  input  logic [31:0] rm_i,
  input  logic        sq_i,
  input  logic        sd_i,
  output logic [31:0] dvd_mag_o,
  output logic [31:0] dvs_mag_o,
  output logic        sd_o,
  output logic        sq_o,
  output logic        ovf_o,
  output logic [15:0] q_o,
  output logic [15:0] r_o
);
  logic        dvs_neg;
  logic [15:0] dvs_abs;
  logic [31:0] qlim;
  logic [15:0] qn, rn;
  logic        unused_rm;

  assign dvs_neg   = is_signed_i & dvs_i[15];
  assign sd_o      = is_signed_i & dvd_i[31];
  assign sq_o      = sd_o ^ dvs_neg;
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign dvd_mag_o = sd_o ? -dvd_i : dvd_i;
  assign dvs_abs   = dvs_neg ? -dvs_i : dvs_i;
  assign dvs_mag_o = {16'h0000, dvs_abs};

  always_comb begin
    qlim = 32'h0;
    if (!is_signed_i) qlim = (size_i == SIZE_WORD) ? 32'h0000_FFFF : 32'h0000_00FF;
    else if (size_i == SIZE_WORD) qlim = sq_i ? 32'h0000_8000 : 32'h0000_7FFF;
    else qlim = sq_i ? 32'h0000_0080 : 32'h0000_007F;
  end

  assign ovf_o = qm_i > qlim;
  // Once range-checked, only the low 16 bits of either result can matter.
  assign qn    = sq_i ? -qm_i[15:0] : qm_i[15:0];
  assign rn    = sd_i ? -rm_i[15:0] : rm_i[15:0];
  assign q_o   = (size_i == SIZE_WORD) ? qn : {8'h00, qn[7:0]};
  assign r_o   = (size_i == SIZE_WORD) ? rn : {8'h00, rn[7:0]};
  assign unused_rm = ^rm_i[31:16];
endmodule

// File: rtl/div_ctrl.sv
// Sequencer between the execution unit and the shared unsigned 32/32 divider
// for DIV/IDIV: zero check, launch with magnitudes, timeout, sign fix-up, #DE range.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WAIT_MAX = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        size,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic [1:0]  err,
  output logic        div_valid,
  output logic [31:0] div_denom,
  output logic [31:0] div_num,
  output logic        div_signed,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_ready
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  state_e        state_q, state_d;
  op_s           op_q, op_d;
  logic          sd_q, sd_d, sq_q, sq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   quot_q, quot_d, rem_q, rem_d;
  err_e          err_q, err_d;
  logic [31:0]   denom_q, denom_d, num_q, num_d;

  logic [31:0]   dvd_mag, dvs_mag;
  logic          sd_chk, sq_chk, ovf;
  logic [15:0]   q_fix, r_fix;

  div_sign_fix u_fix (
    .size_i      (op_q.size),
    .is_signed_i (op_q.sgn),
    .dvd_i       (op_q.dvd),
    .dvs_i       (op_q.dvs),
    .qm_i        (div_q),
    .rm_i        (div_r),
    .sq_i        (sq_q),
    .sd_i        (sd_q),
    .dvd_mag_o   (dvd_mag),
    .dvs_mag_o   (dvs_mag),
    .sd_o        (sd_chk),
    .sq_o        (sq_chk),
    .ovf_o       (ovf),
    .q_o         (q_fix),
    .r_o         (r_fix)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sd_d    = sd_q;
    sq_d    = sq_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    denom_d = denom_q;
    num_d   = num_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_d.size = size;
          op_d.sgn  = is_signed;
          op_d.dvd  = (size == SIZE_WORD) ? dividend
                    : {{16{is_signed & dividend[15]}}, dividend[15:0]};
          op_d.dvs  = (size == SIZE_WORD) ? divisor
                    : {{8{is_signed & divisor[7]}}, divisor[7:0]};
          state_d   = S_CHECK;
        end
        S_CHECK: begin
          if (op_q.dvs == 16'h0000) begin
            err_d   = ERR_ZERO;
            state_d = S_DONE;
          end else begin
            denom_d = dvd_mag;
            num_d   = dvs_mag;
            sd_d    = sd_chk;
            sq_d    = sq_chk;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (div_ready) begin
            state_d = S_FIX;
          end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          if (ovf) begin
            err_d = ERR_OVF;
          end else begin
            quot_d = q_fix;
            rem_d  = r_fix;
            err_d  = ERR_NONE;
          end
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sd_q    <= 1'b0;
      sq_q    <= 1'b0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= ERR_NONE;
      denom_q <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sd_q    <= sd_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      denom_q <= denom_d;
      num_q   <= num_d;
    end
  end

  // Status decoded straight from the state register so reset clears it at once.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign div_valid  = (state_q == S_RUN);
  assign div_signed = 1'b0;
  assign quotient   = quot_q;
  assign remainder  = rem_q;
  assign err        = err_q;
  assign div_denom  = denom_q;
  assign div_num    = num_q;
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencer between the execution unit and the shared 32/32 iterative divider for 286 DIV/IDIV (byte: AX/r8, word: DX:AX/r16).
- Latches operands and detects divide-by-zero before launching the divider.
- Drives the divider unsigned with operand magnitudes, applies x86 sign rules (quotient sign = dividend^divisor, remainder sign = dividend), and checks quotient range for #DE.
- Guarantees the divider's re-arm gap (valid low) between operations.

Parameters:
WAIT_MAX, 40, cycles in RUN without div_ready before timeout error (divider nominally needs 33).

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
size  in  1  0=byte (dividend[15:0], divisor[7:0]), 1=word (dividend[31:0], divisor[15:0])
is_signed  in  1  1=IDIV, 0=DIV
dividend  in  32  DX:AX (word) or AX in [15:0] (byte)
divisor  in  16  r/m operand
abort  in  1  synchronous cancel; forces IDLE
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle completion pulse
quotient  out  16  byte mode: [7:0] valid, [15:8]=0
remainder  out  16  byte mode: [7:0] valid, [15:8]=0
err  out  2  00 ok, 01 zero divisor, 10 quotient overflow, 11 timeout; valid with done
div_valid  out  1  divider run enable
div_denom  out  32  divider dividend (magnitude)
div_num  out  32  divider divisor (magnitude, zero-extended)
div_signed  out  1  constant 0
div_q  in  32  divider quotient
div_r  in  32  divider remainder
div_ready  in  1  divider completion level

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=00, quotient=0, remainder=0, div_valid=0, div_denom=0, div_num=0, all internal registers 0.
- IDLE: on start, register operands; sign-extend (signed) or zero-extend the byte divisor to 16 bits and the byte dividend to 32 bits; busy=1 -> CHECK.
- CHECK: if the effective divisor is 0, set err=01 -> DONE. Otherwise load div_denom and div_num with magnitudes, latch sd = dividend sign and sq = dividend sign ^ divisor sign (both 0 when unsigned) -> RUN.
- Magnitude of 0x80000000 is 0x80000000 (unsigned 32-bit, no overflow).
- RUN: div_valid=1; count cycles. div_ready=1 -> FIX. If count reaches WAIT_MAX first, set err=11 -> DONE.
- div_valid drops on leaving RUN; operands must stay stable throughout RUN.
- FIX: div_valid=0. Compute qm=div_q, rm=div_r.
  - Unsigned overflow: byte qm>0xFF, word qm>0xFFFF.
  - Signed overflow: sq=0 requires qm<=0x7F (byte) or 0x7FFF (word); sq=1 requires qm<=0x80 or 0x8000.
  - On overflow set err=10; quotient and remainder keep their previous values.
  - Otherwise quotient = sq ? -qm : qm, remainder = sd ? -rm : rm, truncated to 8 or 16 bits; err=00 -> DONE.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE (busy=0 next cycle).
- Nominal latency, start to done: 1 (CHECK) + 33 (RUN) + 1 (FIX) + 1 = 36 cycles. Zero divisor: done 2 cycles after start.
- div_valid is low for at least 3 cycles between consecutive RUNs (FIX, DONE, IDLE/CHECK), so the divider re-arms.
- start while not IDLE: ignored.
- abort in any state: next cycle IDLE, div_valid=0, busy=0, no done pulse, outputs unchanged. abort has priority over div_ready in the same cycle.
- reset_n low mid-operation: immediate return to reset values; div_valid low asynchronously.
- err holds its value until the next done.

Decomposition:
- Shared package div_pkg: state encoding (IDLE, CHECK, RUN, FIX, DONE), err codes (ERR_NONE/ZERO/OVF/TIMEOUT), SIZE_BYTE/SIZE_WORD.
- One natural sub-module, div_sign_fix: combinational magnitude/negate and range check, reused by CHECK and FIX.
- The divider itself is instantiated by the parent, not inside this block.

Test Plan:
- Unsigned word: dividend 0x00010000, divisor 0x0002 -> quotient 0x8000, remainder 0x0000, err 00, done 36 cycles after start, one div_valid burst.
- Signed word: dividend 0xFFFFFFF9 (-7), divisor 0x0002 -> quotient 0xFFFD, remainder 0xFFFF, err 00.
- Signed byte edge: dividend 0xFF80 (-128), divisor 0x01 -> quotient 0x0080, remainder 0x0000, err 00. Then dividend 0x0080, divisor 0x01 -> err 10, outputs unchanged.
- Zero divisor: word, divisor 0x0000 -> err 01, done 2 cycles after start, div_valid never asserted.
- Timeout/abort: hold div_ready=0 -> err 11 at count 40. Separately, abort on cycle 10 of RUN -> busy 0 and div_valid 0 next cycle, no done. Separately, reset_n low mid-RUN -> all outputs at reset values immediately.
- Back-to-back: start asserted continuously -> second op accepted in IDLE, div_valid low >=3 cycles between runs, both results correct.
